// File: rtl/sad_pkg.sv
// Shared constants for the sub-pel SAD search: position encoding, row SAD width,
// and the order in which the five positions are compared.
package sad_pkg;

   localparam int SAD_ROW_W = 13;
   localparam int NUM_POS   = 5;

   localparam logic [2:0] POS_LH   = 3'd0;
   localparam logic [2:0] POS_LQ   = 3'd1;
   localparam logic [2:0] POS_FULL = 3'd2;
   localparam logic [2:0] POS_RQ   = 3'd3;
   localparam logic [2:0] POS_RH   = 3'd4;

   // Full-pel first, then quarters, then halves: earlier entries win cost ties.
   function automatic logic [2:0] scan_pos(input int unsigned idx);
      case (idx)
         0:       scan_pos = POS_FULL;
         1:       scan_pos = POS_LQ;
         2:       scan_pos = POS_RQ;
         3:       scan_pos = POS_LH;
         default: scan_pos = POS_RH;
      endcase
   endfunction

endpackage

// File: rtl/sad_best5.sv
// Combinational argmin of five accumulated SAD totals against the incoming best cost.
// Strict less-than, so ties keep whichever came first in scan order (or the incoming best).
module sad_best5
   import sad_pkg::*;
#(
   parameter int ACC_W = 16
) (
   input  logic [NUM_POS*ACC_W-1:0] totals,
   input  logic [ACC_W-1:0]         best_in,
   output logic                     better,
   output logic [2:0]               pos,
   output logic [ACC_W-1:0]         cost
);

   logic [2:0]       scan_p;
   logic [ACC_W-1:0] tot;

   always_comb begin
      better = 1'b0;
      pos    = POS_FULL;
      cost   = best_in;
      scan_p = POS_FULL;
      tot    = '0;
      for (int i = 0; i < NUM_POS; i++) begin
         scan_p = scan_pos(i);
         tot    = totals[int'(scan_p)*ACC_W +: ACC_W];
         if (tot < cost) begin
            better = 1'b1;
            pos    = scan_p;
            cost   = tot;
         end
      end
   end

endmodule

// File: rtl/sad_search_ctrl.sv
// Sequences compute_sad over NUM_CAND integer candidates x ROWS rows, accumulating the five
// per-row sub-pel SADs and tracking the best (candidate, position, cost).
//
//  state   | meaning
//  IDLE    | waiting for start; best_* outputs hold the previous result
//  RUN     | issuing one filter/reference row read per cycle
//  DRAIN   | no read; last row of the last candidate accumulates
//  FINAL   | last candidate evaluated; done pulse, best_* presented
module sad_search_ctrl
   import sad_pkg::*;
#(
   parameter int ROWS     = 8,
   parameter int NUM_CAND = 8,
   parameter int ROW_W    = 3,
   parameter int CAND_W   = 3,
   parameter int ACC_W    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic [CAND_W-1:0]       best_cand,
   output logic [2:0]              best_pos,
   output logic [ACC_W-1:0]        best_cost,
   output logic                    filt_rd_en,
   output logic [ROW_W-1:0]        filt_rd_addr,
   input  logic [63:0]             filt_rd_data,
   output logic                    ref_rd_en,
   output logic [CAND_W+ROW_W-1:0] ref_rd_addr,
   input  logic [63:0]             ref_rd_data,
   output logic [63:0]             sad_filter_pix,
   output logic [63:0]             sad_ref_pix,
   output logic                    sad_input_ready,
   input  logic [NUM_POS*SAD_ROW_W-1:0] sad_in
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_FINAL = 2'd3;

   localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
   localparam logic [CAND_W-1:0] LAST_CAND = CAND_W'(NUM_CAND - 1);

   logic [1:0]               state;
   logic [ROW_W-1:0]         row_cnt;
   logic [CAND_W-1:0]        cand_cnt;
   logic                     vld_d;
   logic [ROW_W-1:0]         row_d;
   logic [CAND_W-1:0]        cand_d;
   logic [NUM_POS*ACC_W-1:0] acc;
   logic [NUM_POS*ACC_W-1:0] acc_next;
   logic [NUM_POS*ACC_W-1:0] snap;
   logic [CAND_W-1:0]        snap_cand;
   logic                     eval_vld;
   logic [ACC_W-1:0]         best_cost_r;
   logic [CAND_W-1:0]        best_cand_r;
   logic [2:0]               best_pos_r;
   logic [ACC_W-1:0]         best_cost_q;
   logic [CAND_W-1:0]        best_cand_q;
   logic [2:0]               best_pos_q;
   logic                     eval_better;
   logic [2:0]               eval_pos;
   logic [ACC_W-1:0]         eval_cost;
   logic [ACC_W-1:0]         fin_cost;
   logic [CAND_W-1:0]        fin_cand;
   logic [2:0]               fin_pos;
   logic                     row_last;

   assign row_last = vld_d && (row_d == LAST_ROW);

   always_comb begin
      acc_next = acc;
      for (int k = 0; k < NUM_POS; k++) begin
         if (row_d == '0)
            acc_next[k*ACC_W +: ACC_W] = ACC_W'(sad_in[k*SAD_ROW_W +: SAD_ROW_W]);
         else
            acc_next[k*ACC_W +: ACC_W] = acc[k*ACC_W +: ACC_W]
                                       + ACC_W'(sad_in[k*SAD_ROW_W +: SAD_ROW_W]);
      end
   end

   sad_best5 #(.ACC_W(ACC_W)) u_best5 (
      .totals  (snap),
      .best_in (best_cost_r),
      .better  (eval_better),
      .pos     (eval_pos),
      .cost    (eval_cost)
   );

   // The last candidate is evaluated in FINAL itself, so its verdict is folded in here.
   assign fin_cost = eval_better ? eval_cost : best_cost_r;
   assign fin_cand = eval_better ? snap_cand : best_cand_r;
   assign fin_pos  = eval_better ? eval_pos  : best_pos_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         row_cnt     <= '0;
         cand_cnt    <= '0;
         vld_d       <= 1'b0;
         row_d       <= '0;
         cand_d      <= '0;
         acc         <= '0;
         snap        <= '0;
         snap_cand   <= '0;
         eval_vld    <= 1'b0;
         best_cost_r <= '1;
         best_cand_r <= '0;
         best_pos_r  <= '0;
         best_cost_q <= '0;
         best_cand_q <= '0;
         best_pos_q  <= '0;
      end else begin
         vld_d    <= (state == S_RUN);
         row_d    <= row_cnt;
         cand_d   <= cand_cnt;
         eval_vld <= row_last;

         if (vld_d)
            acc <= acc_next;

         // Snapshot lets candidate c be judged while c+1 starts accumulating.
         if (row_last) begin
            snap      <= acc_next;
            snap_cand <= cand_d;
         end

         if (eval_vld && eval_better) begin
            best_cost_r <= eval_cost;
            best_cand_r <= snap_cand;
            best_pos_r  <= eval_pos;
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_RUN;
                  row_cnt     <= '0;
                  cand_cnt    <= '0;
                  acc         <= '0;
                  best_cost_r <= '1;
                  best_cand_r <= '0;
                  best_pos_r  <= '0;
               end
            end
            S_RUN: begin
               if (row_cnt == LAST_ROW) begin
                  row_cnt <= '0;
                  if (cand_cnt == LAST_CAND) begin
                     cand_cnt <= '0;
                     state    <= S_DRAIN;
                  end else begin
                     cand_cnt <= cand_cnt + 1'b1;
                  end
               end else begin
                  row_cnt <= row_cnt + 1'b1;
               end
            end
            S_DRAIN: state <= S_FINAL;
            S_FINAL: begin
               best_cost_q <= fin_cost;
               best_cand_q <= fin_cand;
               best_pos_q  <= fin_pos;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy            = (state != S_IDLE);
   assign done            = (state == S_FINAL);
   assign filt_rd_en      = (state == S_RUN);
   assign ref_rd_en       = (state == S_RUN);
   assign filt_rd_addr    = row_cnt;
   assign ref_rd_addr     = {cand_cnt, row_cnt};
   assign sad_filter_pix  = filt_rd_data;
   assign sad_ref_pix     = ref_rd_data;
   assign sad_input_ready = vld_d;
   assign best_cost       = done ? fin_cost : best_cost_q;
   assign best_cand       = done ? fin_cand : best_cand_q;
   assign best_pos        = done ? fin_pos  : best_pos_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Scoreboard bench for sad_search_ctrl: the bench plays row buffers and compute_sad from a
// per-search table, and predicts the winner by direct summation over that table.
module tb_sad_search_ctrl;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         busy, done;
   logic [2:0]   best_cand;
   logic [2:0]   best_pos;
   logic [15:0]  best_cost;
   logic         filt_rd_en, ref_rd_en;
   logic [2:0]   filt_rd_addr;
   logic [5:0]   ref_rd_addr;
   logic [63:0]  filt_rd_data = '0;
   logic [63:0]  ref_rd_data = '0;
   logic [63:0]  sad_filter_pix, sad_ref_pix;
   logic         sad_input_ready;
   logic [64:0]  sad_in = '0;

   sad_search_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .busy            (busy),
      .done            (done),
      .best_cand       (best_cand),
      .best_pos        (best_pos),
      .best_cost       (best_cost),
      .filt_rd_en      (filt_rd_en),
      .filt_rd_addr    (filt_rd_addr),
      .filt_rd_data    (filt_rd_data),
      .ref_rd_en       (ref_rd_en),
      .ref_rd_addr     (ref_rd_addr),
      .ref_rd_data     (ref_rd_data),
      .sad_filter_pix  (sad_filter_pix),
      .sad_ref_pix     (sad_ref_pix),
      .sad_input_ready (sad_input_ready),
      .sad_in          (sad_in)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int cand;
      int pos;
      int cost;
      int start_cyc;
   } exp_t;

   exp_t       sbq[$];
   logic [12:0] tab [64][5];
   int          n_checks = 0;
   int          n_pass = 0;
   int          rd_idx = 0;
   logic        nxt_en = 1'b0;
   logic [5:0]  nxt_addr = '0;
   int          last_cost = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [64:0] pack_row(input logic [5:0] a);
      logic [64:0] v;
      v = '0;
      for (int k = 0; k < 5; k++) v[13*k +: 13] = tab[a][k];
      return v;
   endfunction

   // Row-buffer / compute_sad stand-in: data for a read appears the cycle after it.
   always @(negedge clk) begin
      if (rst) begin
         nxt_en = 1'b0;
      end else begin
         check("input_ready", sad_input_ready, nxt_en);
         if (ref_rd_en) begin
            check("ref_addr", ref_rd_addr, rd_idx);
            check("filt_addr", filt_rd_addr, rd_idx % 8);
            check("filt_en", filt_rd_en, 1);
            rd_idx++;
         end
         nxt_en   = ref_rd_en;
         nxt_addr = ref_rd_addr;
      end
   end

   always @(posedge clk) begin
      logic [95:0] r;
      #1;
      r            = {$urandom, $urandom, $urandom};
      filt_rd_data = r[63:0];
      ref_rd_data  = {r[31:0], r[95:64]};
      if (nxt_en) sad_in = pack_row(nxt_addr);
      else        sad_in = r[64:0];
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         if (sbq.size() == 0) begin
            check("unexpected_done", done, 0);
         end else begin
            e = sbq.pop_front();
            check("best_cand", best_cand, e.cand);
            check("best_pos", best_pos, e.pos);
            check("best_cost", best_cost, e.cost);
            check("latency", cyc - e.start_cyc, 66);
            check("busy_at_done", busy, 1);
         end
      end
   end

   task automatic fill(input int mode);
      for (int a = 0; a < 64; a++)
         for (int k = 0; k < 5; k++)
            case (mode)
               0: tab[a][k] = 13'd0;
               1: tab[a][k] = (a / 8 == 5 && k == 1) ? 13'd10 : 13'd100;
               2: tab[a][k] = 13'd7;
               3: tab[a][k] = 13'd8191;
               4: tab[a][k] = 13'($urandom_range(0, 8191));
               default: tab[a][k] = 13'($urandom_range(0, 3));
            endcase
   endtask

   function automatic exp_t model();
      exp_t e;
      int   ord[5] = '{2, 1, 3, 0, 4};
      int   tot;
      e.cand = 0; e.pos = 0; e.cost = 65535; e.start_cyc = 0;
      for (int c = 0; c < 8; c++)
         for (int i = 0; i < 5; i++) begin
            tot = 0;
            for (int r = 0; r < 8; r++) tot += int'(tab[c*8 + r][ord[i]]);
            if (tot < e.cost) begin
               e.cand = c; e.pos = ord[i]; e.cost = tot;
            end
         end
      return e;
   endfunction

   task automatic run_search(input int mode, input bit pulses, input bit do_rst);
      exp_t e;
      bit   aborted;
      aborted = 1'b0;
      fill(mode);
      e = model();
      @(negedge clk);
      start       = 1'b1;
      e.start_cyc = cyc;
      rd_idx      = 0;
      sbq.push_back(e);
      @(negedge clk);
      start = 1'b0;
      for (int i = 2; i < 200 && sbq.size() != 0; i++) begin
         @(negedge clk);
         start = pulses && (i == 10 || i == 40);
         if (do_rst && i == 30) begin
            #2 rst = 1'b1;
            #1;
            check("rst_done", done, 0);
            check("rst_busy", busy, 0);
            check("rst_rd_en", ref_rd_en, 0);
            check("rst_cost", best_cost, 0);
            check("rst_cand", best_cand, 0);
            check("rst_ready", sad_input_ready, 0);
            sbq.delete();
            aborted = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
         end
      end
      start = 1'b0;
      if (sbq.size() != 0) begin
         check("done_timeout", sbq.size(), 0);
         sbq.delete();
      end
      if (!aborted) begin
         @(negedge clk);
         check("hold_cost", best_cost, e.cost);
         check("hold_cand", best_cand, e.cand);
         check("idle_after", busy, 0);
      end else begin
         repeat (100) @(negedge clk);
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #12;
      check("init_done", done, 0);
      check("init_busy", busy, 0);
      check("init_cost", best_cost, 0);
      check("init_rd_en", filt_rd_en, 0);
      check("init_ready", sad_input_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_search(0, 1'b0, 1'b0);
      run_search(1, 1'b0, 1'b0);
      run_search(2, 1'b0, 1'b0);
      run_search(3, 1'b0, 1'b0);
      run_search(4, 1'b1, 1'b0);
      run_search(4, 1'b0, 1'b1);
      run_search(4, 1'b0, 1'b0);
      for (int t = 0; t < 6; t++)
         run_search((t % 2 == 0) ? 5 : 4, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
